// File: rtl/bomb_placer.sv
// bomb_placer: steps the LCG and marks NUM_BOMBS distinct cells, never the safe cell.
// state  | meaning
// IDLE   | waiting for start
// CLEAR  | wipe map, counters and err
// REQ    | change strobe high for one cycle
// WAIT   | generator output settling
// SAMPLE | accept or reject one draw
// FIN    | done pulse; err already set on abort
module bomb_placer #(
    parameter int GRID_CELLS = 64,
    parameter int IDX_W      = 6,
    parameter int NUM_BOMBS  = 10,
    parameter int MAX_DRAWS  = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [IDX_W-1:0]      safe_idx,
    input  logic [7:0]            rand_in,
    output logic                  change,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  wr_valid,
    output logic [IDX_W-1:0]      wr_idx,
    output logic [GRID_CELLS-1:0] bomb_map
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] CLEAR  = 3'd1;
    localparam logic [2:0] REQ    = 3'd2;
    localparam logic [2:0] WAIT   = 3'd3;
    localparam logic [2:0] SAMPLE = 3'd4;
    localparam logic [2:0] FIN    = 3'd5;

    localparam int               CNT_W   = IDX_W + 1;
    localparam logic [CNT_W-1:0] NB_C    = CNT_W'(NUM_BOMBS);
    localparam logic [10:0]      MAX_C   = 11'(MAX_DRAWS);

    logic [2:0]            state_q, state_d;
    logic [IDX_W-1:0]      safe_q, safe_d;
    logic [CNT_W-1:0]      placed_q, placed_d;
    logic [10:0]           draws_q, draws_d;
    logic [GRID_CELLS-1:0] map_q, map_d;
    logic                  err_q, err_d;
    logic                  wr_valid_q, wr_valid_d;
    logic [IDX_W-1:0]      wr_idx_q, wr_idx_d;
    logic                  change_q, change_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic [IDX_W-1:0]      samp_idx;
    logic                  hit;
    logic                  unused_rand;

    // Only the low IDX_W bits form a full-period sequence mod GRID_CELLS.
    assign samp_idx    = rand_in[IDX_W-1:0];
    assign unused_rand = ^rand_in;
    assign hit         = (samp_idx == safe_q) || map_q[samp_idx];

    always_comb begin
        state_d    = state_q;
        safe_d     = safe_q;
        placed_d   = placed_q;
        draws_d    = draws_q;
        map_d      = map_q;
        err_d      = err_q;
        wr_valid_d = 1'b0;
        wr_idx_d   = wr_idx_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    safe_d  = safe_idx;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                map_d    = '0;
                placed_d = '0;
                draws_d  = '0;
                err_d    = 1'b0;
                state_d  = REQ;
            end
            REQ:  state_d = WAIT;
            WAIT: state_d = SAMPLE;
            SAMPLE: begin
                draws_d = draws_q + 11'd1;
                if (!hit) begin
                    map_d[samp_idx] = 1'b1;
                    wr_valid_d      = 1'b1;
                    wr_idx_d        = samp_idx;
                    placed_d        = placed_q + CNT_W'(1);
                end
                // A final placement wins over an exhausted draw budget.
                if (placed_d == NB_C) begin
                    state_d = FIN;
                end else if (draws_d == MAX_C) begin
                    state_d = FIN;
                    err_d   = 1'b1;
                end else begin
                    state_d = REQ;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        change_d = (state_d == REQ);
        busy_d   = (state_d != IDLE);
        done_d   = (state_d == FIN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            safe_q     <= '0;
            placed_q   <= '0;
            draws_q    <= '0;
            map_q      <= '0;
            err_q      <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_idx_q   <= '0;
            change_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            safe_q     <= safe_d;
            placed_q   <= placed_d;
            draws_q    <= draws_d;
            map_q      <= map_d;
            err_q      <= err_d;
            wr_valid_q <= wr_valid_d;
            wr_idx_q   <= wr_idx_d;
            change_q   <= change_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign change   = change_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign wr_valid = wr_valid_q;
    assign wr_idx   = wr_idx_q;
    assign bomb_map = map_q;

endmodule

// File: tb/tb_bomb_placer.sv
// Bench for bomb_placer: three instances (NUM_BOMBS 3, 2, 63) against a run-level schedule model.
module tb_bomb_placer;

    localparam int NI = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_v     [NI];
    logic       start_v   [NI];
    logic       gen_rst_v [NI];
    logic       stub_v    [NI];
    logic [5:0] safe_v    [NI];
    logic [7:0] seed_v    [NI];
    logic [7:0] gen       [NI];
    logic [7:0] rand_w    [NI];

    logic        change_w   [NI];
    logic        busy_w     [NI];
    logic        done_w     [NI];
    logic        err_w      [NI];
    logic        wr_valid_w [NI];
    logic [5:0]  wr_idx_w   [NI];
    logic [63:0] map_w      [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        bomb_placer #(
            .GRID_CELLS(64),
            .IDX_W     (6),
            .NUM_BOMBS ((g == 0) ? 3 : ((g == 1) ? 2 : 63)),
            .MAX_DRAWS (1024)
        ) u_dut (
            .clk     (clk),
            .rst     (rst_v[g]),
            .start   (start_v[g]),
            .safe_idx(safe_v[g]),
            .rand_in (rand_w[g]),
            .change  (change_w[g]),
            .busy    (busy_w[g]),
            .done    (done_w[g]),
            .err     (err_w[g]),
            .wr_valid(wr_valid_w[g]),
            .wr_idx  (wr_idx_w[g]),
            .bomb_map(map_w[g])
        );
    end

    // LCG x' = 5x + 3 mod 256: seed 8 gives 43, 218, 69, 92, 207 ...
    always_comb begin
        for (int i = 0; i < NI; i++) rand_w[i] = stub_v[i] ? 8'd7 : gen[i];
    end

    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (gen_rst_v[i])     gen[i] <= seed_v[i];
            else if (change_w[i]) gen[i] <= gen[i] * 8'd5 + 8'd3;
        end
    end

    function automatic int nb_of(input int i);
        return (i == 0) ? 3 : ((i == 1) ? 2 : 63);
    endfunction

    // Run-level model: on an accepted start the whole draw sequence is precomputed.
    int          cyc = 0;
    bit          active [NI];
    int          t0     [NI];
    int          kd     [NI];
    bit          acc_t  [NI][1024];
    logic [5:0]  idx_t  [NI][1024];
    logic [63:0] emap   [NI];
    logic        eerr   [NI];

    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (rst_v[i]) begin
                active[i] = 1'b0;
                emap[i]   = '0;
                eerr[i]   = 1'b0;
            end else if (start_v[i] && !(active[i] && cyc <= t0[i] + 2 + 3 * kd[i])) begin : pre
                logic [7:0]  x;
                logic [7:0]  v;
                logic [5:0]  ix;
                logic [63:0] m;
                int          placed;
                int          d;
                bit          ok;
                x = gen[i]; m = '0; placed = 0; d = 0; eerr[i] = 1'b0;
                for (int n = 0; n < 1024; n++) begin
                    if (!stub_v[i]) x = x * 8'd5 + 8'd3;
                    v  = stub_v[i] ? 8'd7 : x;
                    ix = v[5:0];
                    ok = (ix != safe_v[i]) && !m[ix];
                    acc_t[i][n] = ok;
                    idx_t[i][n] = ix;
                    if (ok) begin
                        m[ix]  = 1'b1;
                        placed = placed + 1;
                    end
                    d = n + 1;
                    if (placed == nb_of(i)) break;
                    if (d == 1024) begin
                        eerr[i] = 1'b1;
                        break;
                    end
                end
                emap[i]   = m;
                kd[i]     = d;
                t0[i]     = cyc;
                active[i] = 1'b1;
            end
        end
        cyc = cyc + 1;
    end

    int         checks = 0;
    int         errors = 0;
    bit         chk_en = 1'b0;
    int         done_cnt [NI];
    int         done_at  [NI];
    int         wr_n     [NI];
    logic [5:0] wr_log   [NI][64];

    task automatic chk(input string nm, input int i, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s inst%0d cyc %0d got %0h want %0h", nm, i, cyc, got, want);
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < NI; i++) begin
            int   c;
            int   d;
            logic e_busy, e_change, e_done, e_wr;
            logic [5:0] e_idx;
            c        = cyc;
            e_busy   = active[i] && c >= t0[i] + 1 && c <= t0[i] + 2 + 3 * kd[i];
            e_done   = active[i] && c == t0[i] + 2 + 3 * kd[i];
            e_change = active[i] && c >= t0[i] + 2 && c < t0[i] + 2 + 3 * kd[i]
                       && ((c - t0[i] - 2) % 3 == 0);
            d        = c - t0[i] - 5;
            e_wr     = 1'b0;
            e_idx    = '0;
            if (active[i] && d >= 0 && (d % 3 == 0) && (d / 3) < kd[i]) begin
                e_wr  = acc_t[i][d / 3];
                e_idx = idx_t[i][d / 3];
            end
            if (chk_en) begin
                chk("busy", i, 64'(busy_w[i]), 64'(e_busy));
                chk("change", i, 64'(change_w[i]), 64'(e_change));
                chk("done", i, 64'(done_w[i]), 64'(e_done));
                chk("wr_valid", i, 64'(wr_valid_w[i]), 64'(e_wr));
                if (e_wr) chk("wr_idx", i, 64'(wr_idx_w[i]), 64'(e_idx));
                if (!e_busy || e_done) begin
                    chk("bomb_map", i, map_w[i], emap[i]);
                    chk("err", i, 64'(err_w[i]), 64'(eerr[i]));
                end
            end
            if (done_w[i] === 1'b1) begin
                done_cnt[i]++;
                done_at[i] = c;
            end
            if (wr_valid_w[i] === 1'b1 && wr_n[i] < 64) begin
                wr_log[i][wr_n[i]] = wr_idx_w[i];
                wr_n[i]++;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic reseed(input int i, input logic [7:0] s);
        seed_v[i]    = s;
        gen_rst_v[i] = 1'b1;
        step();
        gen_rst_v[i] = 1'b0;
    endtask

    task automatic start_run(input int i, input logic [5:0] s, output int t);
        safe_v[i]   = s;
        wr_n[i]     = 0;
        done_cnt[i] = 0;
        t           = cyc;
        start_v[i]  = 1'b1;
        step();
        start_v[i]  = 1'b0;
    endtask

    task automatic wait_done(input int i, input int budget, input string nm);
        bit seen = 1'b0;
        for (int n = 0; n < budget && !seen; n++) begin
            step();
            if (done_w[i] === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s inst%0d no done within %0d cycles", nm, i, budget);
        end
    endtask

    initial begin
        int          t;
        logic [63:0] want;
        for (int i = 0; i < NI; i++) begin
            rst_v[i] = 1'b1; start_v[i] = 1'b0; gen_rst_v[i] = 1'b1;
            stub_v[i] = 1'b0; safe_v[i] = '0; seed_v[i] = 8'd8;
            done_cnt[i] = 0; done_at[i] = 0; wr_n[i] = 0;
        end
        stub_v[1] = 1'b1;
        step();
        step();
        for (int i = 0; i < NI; i++) begin
            rst_v[i] = 1'b0; gen_rst_v[i] = 1'b0;
        end
        chk_en = 1'b1;
        step();

        // Seed 8, safe 0: placements 43, 26, 5 after three draws.
        reseed(0, 8'd8);
        start_run(0, 6'd0, t);
        wait_done(0, 60, "a_done");
        chk("a_latency", 0, 64'(done_at[0] - t), 64'd11);
        chk("a_count", 0, 64'(wr_n[0]), 64'd3);
        chk("a_wr0", 0, 64'(wr_log[0][0]), 64'd43);
        chk("a_wr1", 0, 64'(wr_log[0][1]), 64'd26);
        chk("a_wr2", 0, 64'(wr_log[0][2]), 64'd5);
        want = (64'd1 << 5) | (64'd1 << 26) | (64'd1 << 43);
        chk("a_map", 0, map_w[0], want);
        chk("a_err", 0, 64'(err_w[0]), 64'd0);
        step();

        // Safe cell 26 rejects the second draw.
        reseed(0, 8'd8);
        start_run(0, 6'd26, t);
        wait_done(0, 60, "b_done");
        chk("b_latency", 0, 64'(done_at[0] - t), 64'd14);
        chk("b_wr0", 0, 64'(wr_log[0][0]), 64'd43);
        chk("b_wr1", 0, 64'(wr_log[0][1]), 64'd5);
        chk("b_wr2", 0, 64'(wr_log[0][2]), 64'd28);
        step();

        // Stuck source at 7: one placement, then abort at the draw budget.
        start_run(1, 6'd0, t);
        wait_done(1, 3200, "c_done");
        chk("c_latency", 1, 64'(done_at[1] - t), 64'd3074);
        chk("c_err", 1, 64'(err_w[1]), 64'd1);
        chk("c_map", 1, map_w[1], 64'd1 << 7);
        chk("c_count", 1, 64'(wr_n[1]), 64'd1);
        chk("c_wr0", 1, 64'(wr_log[1][0]), 64'd7);
        step();

        // Second start during REQ is dropped.
        reseed(0, 8'd8);
        start_run(0, 6'd0, t);
        step();
        start_v[0] = 1'b1;
        step();
        start_v[0] = 1'b0;
        wait_done(0, 60, "d_done");
        for (int n = 0; n < 20; n++) step();
        chk("d_done_count", 0, 64'(done_cnt[0]), 64'd1);
        chk("d_latency", 0, 64'(done_at[0] - t), 64'd11);

        // Reset during WAIT of the second draw, then a clean run from gen value 218.
        reseed(0, 8'd8);
        start_run(0, 6'd0, t);
        for (int n = 0; n < 5; n++) step();
        rst_v[0] = 1'b1;
        step();
        rst_v[0] = 1'b0;
        chk("e_busy_after_rst", 0, 64'(busy_w[0]), 64'd0);
        chk("e_map_after_rst", 0, map_w[0], 64'd0);
        step();
        start_run(0, 6'd0, t);
        wait_done(0, 60, "e_done");
        chk("e_latency", 0, 64'(done_at[0] - t), 64'd11);
        chk("e_wr0", 0, 64'(wr_log[0][0]), 64'd5);
        chk("e_wr1", 0, 64'(wr_log[0][1]), 64'd28);
        chk("e_wr2", 0, 64'(wr_log[0][2]), 64'd15);
        chk("e_err", 0, 64'(err_w[0]), 64'd0);
        step();

        // 63 bombs with cell 63 safe fills every other cell within one period.
        reseed(2, 8'd8);
        start_run(2, 6'd63, t);
        wait_done(2, 250, "f_done");
        chk("f_within_64_draws", 2, 64'((done_at[2] - t) <= 2 + 3 * 64), 64'd1);
        want = {1'b0, {63{1'b1}}};
        chk("f_map", 2, map_w[2], want);
        chk("f_err", 2, 64'(err_w[2]), 64'd0);
        chk("f_count", 2, 64'(wr_n[2]), 64'd63);
        step();

        // Random seeds, safe cells, stray starts and occasional resets.
        for (int r = 0; r < 24; r++) begin
            int i;
            i = ($urandom_range(0, 1) == 1) ? 2 : 0;
            reseed(i, 8'($urandom));
            for (int n = 0; n < 150; n++) begin
                safe_v[i]  = 6'($urandom_range(0, 63));
                start_v[i] = ($urandom_range(0, 19) == 0);
                rst_v[i]   = ($urandom_range(0, 199) == 0);
                step();
            end
            start_v[i] = 1'b0;
            rst_v[i]   = 1'b0;
            for (int n = 0; n < 200; n++) step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
